assoc_acc_array: RTL
====================

// Module: assoc_acc_array
// PURPOSE
//  Parametrised associative-memory score accumulator with built-in argmax. One lane per class
//  sums per-beat similarity scores over a query; after the last beat a sequential scan picks
//  the winning class. Sits between the per-chunk similarity stage and the classifier result regs.
// PARAMETERS
//  NUM_CLASS  26                   number of class lanes
//  IN_W       3                    per-lane input score width (unsigned)
//  ACC_W      7                    per-lane accumulator width (unsigned), ACC_W >= IN_W
//  CLS_W      $clog2(NUM_CLASS)    class index width (derived, not overridden)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  reset, asynchronous, active-high
//  start        in   1                  pulse: clear all lanes, begin new query
//  in_valid     in   1                  score beat valid
//  in_last      in   1                  qualifies in_valid: final beat of query
//  in_ready     out  1                  1 only in ACC state
//  scores       in   NUM_CLASS*IN_W     lane i at [i*IN_W +: IN_W]
//  acc_scores   out  NUM_CLASS*ACC_W    live accumulator values, lane i at [i*ACC_W +: ACC_W]
//  busy         out  1                  state != IDLE
//  done         out  1                  1-cycle pulse, result valid
//  best_class   out  CLS_W              winning lane index
//  best_score   out  ACC_W              winning lane accumulator value
//  ovf          out  1                  sticky: some lane exceeded 2^ACC_W-1 this query
// BEHAVIOUR
//  - Reset: state IDLE; all accumulators, acc_scores, best_class, best_score, ovf, done = 0.
//  - FSM IDLE -> ACC (start) -> SCAN (beat with in_valid&in_last accepted) -> DONE (scan idx
//    reaches NUM_CLASS-1) -> IDLE (unconditional, 1 cycle).
//  - start in any state: next cycle all lanes = 0, ovf = 0, state ACC. start wins over in_valid.
//  - ACC: beat accepted when in_valid&in_ready; acc[i] <= acc[i] + zero-extended scores[i].
//  - in_valid outside ACC ignored, no accumulate; in_last without in_valid ignored.
//  - SCAN: idx 0..NUM_CLASS-1, one lane/cycle; idx 0 loads best unconditionally, later lanes
//    replace only if strictly greater -> ties resolve to lowest index.
//  - Latency: last beat accepted cycle T; SCAN T+1..T+NUM_CLASS; done=1 at T+NUM_CLASS+1.
//  - best_class/best_score update only at done; held until next done or reset.
//  - Accumulators hold across IDLE/SCAN/DONE; acc_scores always reflects registers.
//  - Reset mid-query: immediate return to IDLE, all cleared, no done.
// CONFIGURATION
//  - ASSOC_SAT_EN defined: lane sum clamps at 2^ACC_W-1; ovf sets on any clamp.
//  - ASSOC_SAT_EN undefined: lane sum wraps modulo 2^ACC_W; ovf sets on any carry-out.
// STRUCTURE
//  - Package hdc_assoc_pkg: FSM state enum (IDLE/ACC/SCAN/DONE), default NUM_CLASS/IN_W/ACC_W.
//  - Sub-module assoc_acc_lane: one accumulator lane (clear, add, sat/wrap, overflow out),
//    instantiated NUM_CLASS times via generate; FSM, scan counter, argmax in top.
// TESTING
//  1. Reset asserted mid-ACC -> all outputs 0, busy=0, no done pulse.
//  2. start, 3 beats lane5=7 others=1 -> acc[5]=21, best_class=5, best_score=21,
//     done exactly 27 cycles after last beat accepted (default params).
//  3. Tie: lanes 3 and 10 both total 15, others lower -> best_class=3, best_score=15.
//  4. 20 beats lane0=7 (sum 140): no macro -> acc[0]=12, ovf=1; ASSOC_SAT_EN -> acc[0]=127, ovf=1.
//  5. start after 2 beats of ACC, then 1 beat lane2=4 + last -> acc[2]=4, prior beats discarded.
//  6. in_valid pulses in IDLE and during SCAN -> in_ready=0, accumulators unchanged, result unchanged.

Source files
------------

// File: rtl/hdc_assoc_pkg.sv
// ---------------------------------------------------------------------------
// hdc_assoc_pkg
// Shared definitions for the associative-memory score accumulator:
//   - state_t        : controller FSM states (IDLE / ACC / SCAN / DONE)
//   - DEF_NUM_CLASS  : default number of class lanes
//   - DEF_IN_W       : default per-lane input score width
//   - DEF_ACC_W      : default per-lane accumulator width
// ---------------------------------------------------------------------------
package hdc_assoc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_CLASS = 26;
    localparam int DEF_IN_W      = 3;
    localparam int DEF_ACC_W     = 7;

endpackage : hdc_assoc_pkg

// File: rtl/assoc_acc_lane.sv
// ---------------------------------------------------------------------------
// assoc_acc_lane
// One class lane: an unsigned accumulator that sums zero-extended beat scores.
// Compile-time option ASSOC_SAT_EN:
//   defined   -> sum clamps at 2^ACC_W-1, ovf flags every clamp
//   undefined -> sum wraps modulo 2^ACC_W, ovf flags every carry-out
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   clr    in   clear accumulator to 0 (wins over add)
//   add    in   accumulate score this cycle
//   score  in   [IN_W]   beat score for this lane
//   acc    out  [ACC_W]  accumulator register
//   ovf    out  1-cycle overflow event for the add happening this cycle
// ---------------------------------------------------------------------------
module assoc_acc_lane #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [IN_W-1:0]  score,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int PAD = ACC_W + 1 - IN_W;

    // One extra bit keeps the carry-out of the addition visible.
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;

    assign sum = {1'b0, acc} + {{PAD{1'b0}}, score};
    assign ovf = add & sum[ACC_W];

`ifdef ASSOC_SAT_EN
    assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    // NOTE: the accumulators are reset explicitly (not left to the first clear)
    // because their values are visible on acc_scores straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values, independent of process ordering.
            acc <= acc_nxt;
        end
    end

endmodule : assoc_acc_lane

// File: rtl/assoc_acc_array.sv
// ---------------------------------------------------------------------------
// assoc_acc_array
// Associative-memory score accumulator with built-in argmax. One lane per class
// sums per-beat similarity scores over a query; after the last beat a
// sequential scan (one lane per cycle) picks the winning class. Ties resolve to
// the lowest lane index.
// Compile-time option ASSOC_SAT_EN: saturating lane sums (default: wrapping).
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   start        in   pulse: clear all lanes and ovf, begin a new query
//   in_valid     in   score beat valid
//   in_last      in   final beat of the query (qualified by in_valid)
//   in_ready     out  high only while accumulating
//   scores       in   [NUM_CLASS*IN_W]   lane i at [i*IN_W +: IN_W]
//   acc_scores   out  [NUM_CLASS*ACC_W]  live accumulators, lane i at [i*ACC_W +: ACC_W]
//   busy         out  controller not idle
//   done         out  1-cycle pulse, best_class/best_score just updated
//   best_class   out  [$clog2(NUM_CLASS)] winning lane index
//   best_score   out  [ACC_W]            winning lane accumulator value
//   ovf          out  sticky: some lane overflowed during this query
// ---------------------------------------------------------------------------
module assoc_acc_array
    import hdc_assoc_pkg::*;
#(
    parameter int NUM_CLASS = DEF_NUM_CLASS,
    parameter int IN_W      = DEF_IN_W,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic [NUM_CLASS*IN_W-1:0]     scores,
    output logic [NUM_CLASS*ACC_W-1:0]    acc_scores,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_CLASS)-1:0]  best_class,
    output logic [ACC_W-1:0]              best_score,
    output logic                          ovf
);

    localparam int              CLS_W    = $clog2(NUM_CLASS);
    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [CLS_W-1:0] scan_idx;
    logic             scan_end;

    logic [ACC_W-1:0]     acc_arr [NUM_CLASS];
    logic [NUM_CLASS-1:0] lane_ovf;

    // Running argmax during the scan; published to best_* only at the end.
    logic [ACC_W-1:0] run_score;
    logic [CLS_W-1:0] run_class;
    logic [ACC_W-1:0] cand_score;
    logic             take;
    logic [ACC_W-1:0] nxt_score;
    logic [CLS_W-1:0] nxt_class;

    // start overrides any beat presented in the same cycle.
    assign in_ready = (state == ACC);
    assign accept   = in_valid & in_ready & ~start;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign scan_end = (scan_idx == LAST_IDX);

    // -----------------------------------------------------------------------
    // Lanes
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CLASS; g++) begin : g_lane
        assoc_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (start),
            .add   (accept),
            .score (scores[g*IN_W +: IN_W]),
            .acc   (acc_arr[g]),
            .ovf   (lane_ovf[g])
        );
        assign acc_scores[g*ACC_W +: ACC_W] = acc_arr[g];
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for paths the case does not mention.
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            ACC:     if (accept && in_last) state_nxt = SCAN;
            SCAN:    if (scan_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = ACC;
        end
    end

    // -----------------------------------------------------------------------
    // Argmax step: index 0 always loads, later lanes need a strictly greater
    // score, so the lowest index wins ties.
    // -----------------------------------------------------------------------
    always_comb begin
        cand_score = acc_arr[scan_idx];
        take       = (scan_idx == '0) || (cand_score > run_score);
        nxt_score  = take ? cand_score : run_score;
        nxt_class  = take ? scan_idx   : run_class;
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            scan_idx   <= '0;
            run_score  <= '0;
            run_class  <= '0;
            best_score <= '0;
            best_class <= '0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start) begin
                ovf <= 1'b0;
            end else if (|lane_ovf) begin
                ovf <= 1'b1;
            end

            // A start during the scan aborts it without publishing a result.
            if (state == SCAN && !start) begin
                scan_idx  <= scan_idx + CLS_W'(1);
                run_score <= nxt_score;
                run_class <= nxt_class;
                if (scan_end) begin
                    best_score <= nxt_score;
                    best_class <= nxt_class;
                end
            end else begin
                scan_idx <= '0;
            end
        end
    end

endmodule : assoc_acc_array
